// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants and types for the two-requester multiplier arbiter.
// Imported by the arbiter top and its winner-select helper.
package mul_share_arbiter_pkg;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/Multiplier_4bit.sv
// Combinational 4x4 unsigned shift-add multiplier.
// Shared datapath instance; 8-bit zero-extended product.
module Multiplier_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p + ({4'b0, a} << i);
            end
        end
    end

endmodule

// File: rtl/rr_pick_2.sv
// Two-way round-robin winner select, purely combinational.
// On contention the requester that did not win last time is chosen.
module rr_pick_2
    import mul_share_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_gnt,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = REQ0;
        unique case (1'b1)
            (valid0 && valid1):  grant_id = ~last_gnt;
            (valid1 && !valid0): grant_id = REQ1;
            default:             grant_id = REQ0;
        endcase
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one Multiplier_4bit between two requesters.
// IDLE accepts a pair, MUL registers the product, HOLD presents it.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [PW-1:0]    res_p,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic             last_gnt;
    logic             gnt_valid, gnt_id;
    logic             take;
    logic [PW-1:0]    prod;

    rr_pick_2 u_pick (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_gnt    (last_gnt),
        .grant_valid (gnt_valid),
        .grant_id    (gnt_id)
    );

    Multiplier_4bit u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    // Grants only ever leave the IDLE state, so ready never
    // coincides with a retiring result.
    assign take       = (state == IDLE) && gnt_valid;
    assign req0_ready = take && (gnt_id == REQ0);
    assign req1_ready = take && (gnt_id == REQ1);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_valid) state_nx = MUL;
            MUL:     state_nx = HOLD;
            HOLD:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= REQ0;
            last_gnt  <= REQ1;
            res_valid <= 1'b0;
            res_p     <= '0;
            res_id    <= REQ0;
        end else begin
            if (take) begin
                a_q      <= (gnt_id == REQ1) ? req1_a : req0_a;
                b_q      <= (gnt_id == REQ1) ? req1_b : req0_b;
                id_q     <= gnt_id;
                last_gnt <= gnt_id;
            end
            if (state == MUL) begin
                res_p     <= prod;
                res_id    <= id_q;
                res_valid <= 1'b1;
            end
            if ((state == HOLD) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one instance of the existing combinational Multiplier_4bit between two requesters.
- Each requester hands over an operand pair with a valid/ready handshake.
- The block latches the operands, drives the shared multiplier, registers the 8-bit product and presents it on a single result port tagged with the requester id.
- Sits between operand producers and a single result consumer in the Lab 2 arithmetic datapath.

Parameters:
WIDTH, 4, operand width; only 4 is supported (shared Multiplier_4bit is fixed-width); product width is 2*WIDTH = 8.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  4  requester 0 multiplicand
req0_b  input  4  requester 0 multiplier
req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  4  requester 1 multiplicand
req1_b  input  4  requester 1 multiplier
req1_ready  output  1  requester 1 pair accepted this cycle when high with req1_valid
res_valid  output  1  result register holds a product
res_p  output  8  product a*b
res_id  output  1  requester that owns res_p (0 or 1)
res_ready  input  1  consumer takes result when high with res_valid
busy  output  1  high whenever state is not IDLE

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low.
- Reset values: state IDLE, res_valid 0, res_p 0, res_id 0, busy 0, operand registers 0, last_gnt 1 (requester 0 wins the first contest).
- FSM states:
  - IDLE: accepts requests.
  - MUL: operand registers drive Multiplier_4bit.
  - HOLD: result presented on the result port.
- IDLE:
  - Grant logic is combinational.
  - Only one requester valid: that requester wins.
  - Both valid: the requester != last_gnt wins.
  - winner's reqX_ready = 1; the loser's ready = 0.
  - Transfer on the edge where valid && ready: latch a, b and id; last_gnt <= id; go to MUL.
  - No requester valid: stay in IDLE, both ready = 0.
- MUL (exactly 1 cycle):
  - res_p <= multiplier output; res_id <= latched id; res_valid <= 1; go to HOLD.
- HOLD:
  - res_valid, res_p and res_id are held stable until res_ready = 1.
  - On that edge: res_valid <= 0; go to IDLE.
- reqX_ready is 0 in MUL and HOLD. A new request is never accepted in the same cycle a result retires.
- Latency: transfer edge N -> res_valid high after edge N+1. Minimum issue interval 3 cycles (res_ready held high).
- Arithmetic: unsigned, zero-extended to 8 bits; no overflow possible (max 15*15 = 225).
- res_ready while res_valid = 0 is ignored.
- Requesters must hold valid and operands stable until ready. The arbiter samples only on the transfer edge.
- A requester that drops valid before being granted loses no slot: the other requester, if valid, is granted.
- Reset asserted mid-operation (MUL or HOLD): the pending result is discarded, res_valid drops asynchronously, state goes to IDLE, last_gnt is set to 1.
- busy = (state != IDLE), registered-state derived, no glitch paths from inputs.

Decomposition:
- Shared package holds:
  - WIDTH
  - state encoding constants (IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2)
  - requester id constants REQ0 = 1'b0, REQ1 = 1'b1
- Sub-modules:
  - The existing Multiplier_4bit is instantiated once as the shared datapath.
  - One new sub-module, rr_pick_2, holds the combinational winner selection (inputs: two valids, last_gnt; outputs: grant_valid, grant_id).
  - FSM and registers stay in mul_share_arbiter.

Test Plan:
- Reset: drive rst_n = 0 in HOLD with res_p = 15 -> res_valid 0 immediately without clock edge, busy 0. After release, both requesters valid -> req0_ready = 1 first.
- Single request: req0 a = 3, b = 5, res_ready = 1 -> req0_ready high in cycle 0; res_valid high 2 cycles later with res_p = 15, res_id = 0; busy 1 for 2 cycles.
- Contention: req0 (15,15) and req1 (7,9) held valid continuously -> results in order: id 0 p = 225, id 1 p = 63, id 0 p = 225, alternating strictly.
- Backpressure: hold res_ready = 0 for 5 cycles in HOLD -> res_valid, res_p and res_id stable, req0_ready = req1_ready = 0, busy = 1. Release -> retire, then next grant.
- Exhaustive: req1 alone sweeps all 256 (a,b) pairs -> every res_p == a*b, res_id == 1, no result dropped or duplicated.
- Lone requester: req1 valid after req1 was just served, req0 idle -> req1 granted again in the next IDLE cycle, no wasted slot.
